rv64_icache: RTL and testbench
==============================

RV64_ICACHE -- requirements
Module: rv64_icache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped lines (power of 2, ≥2); line = 32 bytes = 4 x 64-bit beats.
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have if_valid  input  1  core fetch request, held until completion.
REQ-005 SHALL have if_addr  input  64  fetch byte address, stable while if_valid.
REQ-006 SHALL have if_ready, if_rvalid  output  1 each  completion strobe; both asserted together, one cycle.
REQ-007 SHALL have if_rdata  output  32  instruction word.
REQ-008 SHALL have if_err  output  1  fetch fault, valid with if_rvalid.
REQ-009 SHALL have flush  input  1  invalidate all lines (FENCE.I).
REQ-010 SHALL have m_valid  output  1, m_addr  output  64  refill read request to memory.
REQ-011 SHALL have m_ready, m_rvalid  input  1 each  beat completes on cycle with m_valid&&m_ready&&m_rvalid.
REQ-012 SHALL have m_rdata  input  64  refill beat; m_err  input  1  beat fault.
REQ-013 SHALL have stat_hits, stat_misses  output  32 each  wrapping event counters.

Function
REQ-014 Address split: word sel = addr[2], beat = addr[4:3], index = addr[4+log2(LINES):5], tag = remaining upper bits.
REQ-015 States: IDLE, LOOKUP, FILL, RESP; reset state IDLE.
REQ-016 IDLE: if_valid=1 -> latch if_addr into req_addr, read tag/valid/data at index -> LOOKUP; flush (or pending flush) clears all valid bits this cycle.
REQ-017 Once latched, request SHALL complete irrespective of later if_valid value.
REQ-018 LOOKUP, req_addr[1:0]!=0: if_ready=if_rvalid=if_err=1, if_rdata=0, no fill, no counter change -> IDLE.
REQ-019 LOOKUP hit (valid && tag match): if_ready=if_rvalid=1, if_err=0, if_rdata=selected 32-bit half, stat_hits+1 -> IDLE; hit latency = 1 cycle after request cycle.
REQ-020 LOOKUP miss: stat_misses+1, beat counter=0, clear err flag -> FILL.
REQ-021 FILL: m_valid=1, m_addr={req line base, beat, 3'b000}; m_addr stable until beat completes; beats strictly in order 0..3.
REQ-022 FILL beat completion: write m_rdata to data array at (index,beat); capture requested word if beat==req beat; m_err ORs into err flag; beat 3 -> write tag, set valid only if err flag clear and no flush seen during fill -> RESP; else beat+1.
REQ-023 RESP: if_ready=if_rvalid=1, if_rdata=captured word (0 if err), if_err=err flag -> IDLE.
REQ-024 Zero-wait memory miss latency: request cycle T, LOOKUP T+1, FILL T+2..T+5, response T+6.
REQ-025 flush outside IDLE SHALL be held as pending and applied on next IDLE cycle; flush during FILL suppresses valid for that line.
REQ-026 flush and if_valid same IDLE cycle: invalidate first; lookup of that request SHALL miss.
REQ-027 m_valid, if_ready, if_rvalid, if_err SHALL be 0 in all states other than those stated.
REQ-028 Counters wrap 0xFFFF_FFFF -> 0.

Reset
REQ-029 rst_n low: state IDLE, all valid bits 0, pending flush 0, counters 0, all outputs 0; data/tag arrays need no reset.
REQ-030 rst_n low mid-FILL SHALL abort the fill with no line installed; m_valid drops asynchronously.

Verification
REQ-031 Cold fetch 0x1000, zero-wait memory returning beat n = 0x0000_0000_0000_0013 + n -> m_addr 0x1000,0x1008,0x1010,0x1018; if_rdata 0x13 at T+6; stat_misses=1.
REQ-032 Refetch 0x1004 after REQ-031 -> hit at T+1, no m_valid, if_rdata 0x0000_0000, stat_hits=1.
REQ-033 Fetch 0x2002 -> if_err=1 at T+1, m_valid never asserted, counters unchanged.
REQ-034 Miss with m_err on beat 2 -> if_err=1 at RESP; refetch same address misses again.
REQ-035 flush pulse during FILL of 0x3000 -> response delivered; refetch 0x3000 misses; conflict address 0x3000+32*LINES evicts line.
REQ-036 rst_n asserted during FILL beat 1 -> outputs 0 immediately; after release fetch of same address misses.

Source files
------------

// File: rtl/rv64_icache.sv
// Direct-mapped RV64 instruction cache: 32-byte lines refilled as four 64-bit beats,
// one outstanding fetch, FENCE.I flush held pending until the controller is idle.
module rv64_icache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        flush,
    output logic        m_valid,
    output logic [63:0] m_addr,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [63:0] m_rdata,
    input  logic        m_err,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 59 - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [63:0]      req_addr_r;
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [63:0]      data_mem [LINES*4];
    logic             flush_pend_r, hit_valid_r, tag_match_r, err_r;
    logic [31:0]      rd_word_r, cap_r, hits_r, misses_r;
    logic [1:0]       beat_r;
    logic             hit_s, misaligned_s, beat_done_s, last_beat_s, err_s, flush_any_s;
    logic [IDX_W-1:0] req_idx_s, in_idx_s;

    function automatic logic [31:0] half_sel(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

    assign req_idx_s    = req_addr_r[IDX_W+4:5];
    assign in_idx_s     = if_addr[IDX_W+4:5];
    assign misaligned_s = (req_addr_r[1:0] != 2'b00);
    assign hit_s        = hit_valid_r && tag_match_r;
    assign beat_done_s  = (state_r == FILL) && m_ready && m_rvalid;
    assign last_beat_s  = beat_done_s && (beat_r == 2'd3);
    assign err_s        = err_r | m_err;
    assign flush_any_s  = flush | flush_pend_r;
    assign stat_hits    = hits_r;
    assign stat_misses  = misses_r;

    // State register; reset forces IDLE so an in-flight refill is abandoned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and output decode, all outputs derived from registered state
    always_comb begin
        state_s   = state_r;
        if_ready  = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        if_err    = 1'b0;
        m_valid   = 1'b0;
        m_addr    = 64'd0;
        case (state_r)
            IDLE: begin
                if (if_valid) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (misaligned_s) begin
                    if_ready  = 1'b1;
                    if_rvalid = 1'b1;
                    if_err    = 1'b1;
                    state_s   = IDLE;
                end else if (hit_s) begin
                    if_ready  = 1'b1;
                    if_rvalid = 1'b1;
                    if_rdata  = rd_word_r;
                    state_s   = IDLE;
                end else begin
                    state_s = FILL;
                end
            end
            FILL: begin
                m_valid = 1'b1;
                m_addr  = {req_addr_r[63:5], beat_r, 3'b000};
                if (last_beat_s) begin
                    state_s = RESP;
                end else begin
                    state_s = FILL;
                end
            end
            RESP: begin
                if_ready  = 1'b1;
                if_rvalid = 1'b1;
                if_err    = err_r;
                if_rdata  = err_r ? 32'd0 : cap_r;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request capture, valid bits, pending flush, refill bookkeeping and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_r   <= 64'd0;
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
            hit_valid_r  <= 1'b0;
            tag_match_r  <= 1'b0;
            err_r        <= 1'b0;
            rd_word_r    <= 32'd0;
            cap_r        <= 32'd0;
            hits_r       <= 32'd0;
            misses_r     <= 32'd0;
            beat_r       <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    flush_pend_r <= 1'b0;
                    if (flush_any_s) begin
                        valid_r <= '0;
                    end
                    if (if_valid) begin
                        req_addr_r  <= if_addr;
                        // a flush in this same cycle must make the lookup miss
                        hit_valid_r <= valid_r[in_idx_s] && !flush_any_s;
                        tag_match_r <= (tag_mem[in_idx_s] == if_addr[63 -: TAG_W]);
                        rd_word_r   <= half_sel(data_mem[if_addr[IDX_W+4:3]], if_addr[2]);
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (!misaligned_s) begin
                        if (hit_s) begin
                            hits_r <= hits_r + 32'd1;
                        end else begin
                            // the line is being overwritten, so it stays invalid until a clean fill
                            misses_r           <= misses_r + 32'd1;
                            valid_r[req_idx_s] <= 1'b0;
                            beat_r             <= 2'd0;
                            err_r              <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (beat_done_s) begin
                        beat_r <= beat_r + 2'd1;
                        err_r  <= err_s;
                        if (beat_r == req_addr_r[4:3]) begin
                            cap_r <= half_sel(m_rdata, req_addr_r[2]);
                        end
                        if (last_beat_s && !err_s && !flush_any_s) begin
                            valid_r[req_idx_s] <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                default: begin
                    flush_pend_r <= flush_pend_r;
                end
            endcase
        end
    end

    // Tag and data arrays; contents are qualified by valid_r so they need no reset
    always_ff @(posedge clk) begin
        if (beat_done_s) begin
            data_mem[{req_idx_s, beat_r}] <= m_rdata;
            if (beat_r == 2'd3) begin
                tag_mem[req_idx_s] <= req_addr_r[63 -: TAG_W];
            end
        end
    end

endmodule

// File: tb/tb_rv64_icache.sv
// Randomized bench for rv64_icache: a line-level cache model predicts every response,
// refill address and counter value; directed cases pin the model with literal values.
module tb_rv64_icache;
    localparam int LINES = 64;
    localparam int IDX_W = 6;

    logic        clk, rst_n, if_valid, if_ready, if_rvalid, if_err, flush;
    logic [63:0] if_addr, m_addr, m_rdata;
    logic [31:0] if_rdata, stat_hits, stat_misses;
    logic        m_valid, m_ready, m_rvalid, m_err;

    rv64_icache #(.LINES(LINES)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_addr(if_addr),
        .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .flush(flush), .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    int checks = 0;
    int passes = 0;
    int req_id = 0;
    int resp_done_id = 0;
    int fill_done_id = 0;
    int err_beat = -1;
    int mem_mode = 1;
    int lat;
    int exp_hits = 0;
    int exp_misses = 0;
    bit zero_wait = 1'b1;
    bit exp_fill = 1'b0;
    logic [58:0] exp_line;
    logic [31:0] exp_rdata, got_rdata;
    logic        exp_err, got_err;
    logic [63:0] first_maddr;

    // cache model: per line, valid, line address and the four beats
    bit          mv [LINES];
    logic [58:0] mtag [LINES];
    logic [63:0] mdata [LINES][4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (mem_mode == 1) return 64'h13 + {62'd0, a[4:3]};
        return {a[31:0] ^ 32'h9E37_79B9, ~a[31:0] + a[63:32]};
    endfunction

    // memory responder: random or zero-wait handshakes, data from the address
    initial begin
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'd0; m_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (zero_wait) begin
                m_ready = 1'b1; m_rvalid = 1'b1;
            end else begin
                m_ready  = ($urandom_range(0, 3) != 0);
                m_rvalid = ($urandom_range(0, 3) != 0);
            end
            m_rdata = mem_word(m_addr);
            m_err   = m_valid && (err_beat == int'(m_addr[4:3]));
        end
    end

    // compare process: every cycle check strobes, responses and refill addresses
    initial begin
        int mon_beat;
        mon_beat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_beat = 0;
            end else begin
                chk("ready_eq_rvalid", if_ready, if_rvalid);
                if (if_rvalid) begin
                    if (resp_done_id == req_id) begin
                        chk("spurious_rvalid", 1'b1, 1'b0);
                    end else begin
                        chk("if_rdata", if_rdata, exp_rdata);
                        chk("if_err", if_err, exp_err);
                        resp_done_id = req_id;
                    end
                end else begin
                    chk("if_err_idle", if_err, 1'b0);
                end
                if (m_valid) begin
                    if (!exp_fill || fill_done_id == req_id) begin
                        chk("spurious_m_valid", 1'b1, 1'b0);
                    end else begin
                        chk("m_addr", m_addr, {exp_line, 2'(mon_beat), 3'b000});
                        if (m_ready && m_rvalid) begin
                            if (mon_beat == 3) fill_done_id = req_id;
                            mon_beat = (mon_beat + 1) % 4;
                        end
                    end
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input int ebeat, input bit fl_req,
                         input bit fl_fill_in, input bit zw, input bit hold);
        int idx;
        bit mis, hit, fl_fill;
        logic [63:0] w;
        idx = int'(a[IDX_W+4:5]);
        if (fl_req) model_clear();
        mis = (a[1:0] != 2'b00);
        hit = !mis && mv[idx] && (mtag[idx] == a[63:5]);
        fl_fill = fl_fill_in && !mis && !hit;
        if (mis) begin
            exp_rdata = 32'd0; exp_err = 1'b1;
        end else if (hit) begin
            w = mdata[idx][a[4:3]];
            exp_rdata = a[2] ? w[63:32] : w[31:0]; exp_err = 1'b0;
        end else begin
            w = mem_word({a[63:3], 3'b000});
            exp_err = (ebeat >= 0);
            exp_rdata = exp_err ? 32'd0 : (a[2] ? w[63:32] : w[31:0]);
        end
        exp_fill  = !mis && !hit;
        exp_line  = a[63:5];
        err_beat  = exp_fill ? ebeat : -1;
        zero_wait = zw;
        req_id++;
        if_valid = 1'b1; if_addr = a; flush = fl_req;
        @(posedge clk); #1;
        flush = 1'b0;
        if (!hold) if_valid = 1'b0;
        lat = 1; first_maddr = 64'd0;
        while (!if_rvalid && lat < 200) begin
            if (lat == 2) first_maddr = m_addr;
            if (fl_fill && lat == 3) flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            lat++;
        end
        if_valid = 1'b0;
        got_rdata = if_rdata; got_err = if_err;
        chk("response_in_time", (lat < 200), 1'b1);
        if (!mis) begin
            if (hit) exp_hits++;
            else begin
                exp_misses++;
                mv[idx] = 1'b0;
                if (ebeat < 0 && !fl_fill) begin
                    mv[idx] = 1'b1; mtag[idx] = a[63:5];
                    for (int b = 0; b < 4; b++) mdata[idx][b] = mem_word({a[63:5], 2'(b), 3'b000});
                end
            end
        end
        if (fl_fill) model_clear();
        @(posedge clk); #1;
        err_beat = -1; exp_fill = 1'b0;
        chk("stat_hits", stat_hits, 32'(exp_hits));
        chk("stat_misses", stat_misses, 32'(exp_misses));
        if (mis || hit) chk("short_latency", lat, 1);
        else if (zw) chk("miss_latency", lat, 6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        logic [52:0] t;
        rst_n = 1'b0; if_valid = 1'b0; if_addr = 64'd0; flush = 1'b0;
        model_clear();
        #3;
        chk("rst_outputs", {if_ready, if_rvalid, if_err, m_valid}, 4'b0000);
        chk("rst_counters", {stat_hits, stat_misses}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // cold fetch, hit refetch, misaligned
        fetch(64'h1000, -1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("cold_rdata", got_rdata, 32'h13);
        chk("cold_first_maddr", first_maddr, 64'h1000);
        chk("cold_latency", lat, 6);
        chk("cold_misses", stat_misses, 32'd1);
        fetch(64'h1004, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit_latency", lat, 1);
        chk("hit_rdata", got_rdata, 32'h0);
        chk("hit_count", stat_hits, 32'd1);
        fetch(64'h2002, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("misaligned_err", got_err, 1'b1);
        chk("misaligned_cnt", {stat_hits, stat_misses}, {32'd1, 32'd1});

        // beat error, then the same line must miss again
        fetch(64'h4000, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("beat_err", got_err, 1'b1);
        fetch(64'h4000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("err_refetch_miss", stat_misses, 32'd3);

        // flush during fill, conflict eviction, flush with request
        fetch(64'h3000, -1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("flush_fill_rdata", got_rdata, 32'h13);
        fetch(64'h3000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_refetch_miss", stat_misses, 32'd5);
        fetch(64'h3000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("refill_hit", stat_hits, 32'd2);
        fetch(64'h3000 + 64'(32 * LINES), -1, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch(64'h3000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("evicted_miss", stat_misses, 32'd7);
        fetch(64'h1000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch(64'h1000, -1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_same_cycle_miss", stat_misses, 32'd9);

        // reset in the middle of a refill
        exp_fill = 1'b1; exp_line = 59'h280; err_beat = -1; zero_wait = 1'b1; req_id++;
        if_valid = 1'b1; if_addr = 64'h5000;
        @(posedge clk); #1 if_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fill_beat1_addr", m_addr, 64'h5008);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drops_m_valid", m_valid, 1'b0);
        chk("rst_outputs_mid", {if_ready, if_rvalid, if_err}, 3'b000);
        model_clear(); exp_hits = 0; exp_misses = 0; exp_fill = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        fetch(64'h5000, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_miss", stat_misses, 32'd1);

        // randomized traffic against the model
        mem_mode = 0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: t = 53'd0;
                1: t = 53'd1;
                2: t = 53'd5;
                default: t = 53'h1F_FFFF_FFFF_FFFF;
            endcase
            a = {t, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
